// File: rtl/control_unit_seq.sv
// Sequencing control unit: IDLE/RUN/WAIT/HALT FSM, opcode decode to
// datapath control lines, and a saturating retired-instruction counter.
module control_unit_seq #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             start,
   input  logic             step_mode,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we,
   output logic             wez,
   output logic [2:0]       ALUOp,
   output logic             pc_en,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2,
      HALT = 2'd3
   } state_t;

   localparam logic [5:0] OP_J    = 6'b110000;
   localparam logic [5:0] OP_JZ   = 6'b110001;
   localparam logic [5:0] OP_JNZ  = 6'b110010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   state_t state, state_nx;

   logic is_alu;
   logic is_ldi;
   logic is_j;
   logic is_jz;
   logic is_jnz;
   logic is_halt;

   assign is_alu  = ~opcode[5];
   assign is_ldi  = (opcode[5:2] == 4'b1000);
   assign is_j    = (opcode == OP_J);
   assign is_jz   = (opcode == OP_JZ);
   assign is_jnz  = (opcode == OP_JNZ);
   assign is_halt = (opcode == OP_HALT);

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            if (is_halt)        state_nx = HALT;
            else if (step_mode) state_nx = WAIT;
            else                state_nx = RUN;
         end
         WAIT: if (start) state_nx = RUN;
         HALT: state_nx = HALT;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs hold their quiet values outside RUN; decode only in RUN.
   always_comb begin
      s_inc = 1'b1;
      s_inm = 1'b0;
      we    = 1'b0;
      wez   = 1'b0;
      ALUOp = 3'b000;
      pc_en = 1'b0;
      if (state == RUN) begin
         pc_en = 1'b1;
         unique case (1'b1)
            is_alu: begin
               ALUOp = opcode[4:2];
               we    = 1'b1;
               wez   = 1'b1;
            end
            is_ldi: begin
               s_inm = 1'b1;
               we    = 1'b1;
            end
            is_j:    s_inc = 1'b0;
            is_jz:   s_inc = ~zero;
            is_jnz:  s_inc = zero;
            is_halt: pc_en = 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         instr_count <= '0;
      else if (state == RUN && !is_halt && !(&instr_count))
         instr_count <= instr_count + 1'b1;
   end

   assign busy   = (state == RUN);
   assign halted = (state == HALT);

endmodule

// File: tb/tb_control_unit_seq.sv
// Directed bench for control_unit_seq, using a 4-bit counter so the
// saturation boundary is reachable within a short run.
module tb_control_unit_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       start;
   logic       step_mode;
   logic       s_inc;
   logic       s_inm;
   logic       we;
   logic       wez;
   logic [2:0] ALUOp;
   logic       pc_en;
   logic       busy;
   logic       halted;
   logic [3:0] instr_count;

   int n_chk  = 0;
   int n_fail = 0;
   int runs;
   int pens;

   control_unit_seq #(.CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .zero        (zero),
      .start       (start),
      .step_mode   (step_mode),
      .s_inc       (s_inc),
      .s_inm       (s_inm),
      .we          (we),
      .wez         (wez),
      .ALUOp       (ALUOp),
      .pc_en       (pc_en),
      .busy        (busy),
      .halted      (halted),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_pc_en"}, 32'(pc_en), 32'd0);
      chk({tag, "_we"},    32'(we),    32'd0);
      chk({tag, "_wez"},   32'(wez),   32'd0);
      chk({tag, "_s_inc"}, 32'(s_inc), 32'd1);
      chk({tag, "_s_inm"}, 32'(s_inm), 32'd0);
      chk({tag, "_aluop"}, 32'(ALUOp), 32'd0);
      chk({tag, "_busy"},  32'(busy),  32'd0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; step_mode = 1'b0;
      opcode = 6'b000000; zero = 1'b0;
      tick(); tick();
      reset = 1'b1;
      #1;
      chk_idle("rst");
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      opcode = 6'b000100;
      for (int i = 0; i < 5; i++) tick();
      chk_idle("idle5");
      chk("idle5_count", 32'(instr_count), 32'd0);

      // free-running program: ALU, LOADI, HALT
      start = 1'b1; tick(); start = 1'b0;
      opcode = 6'b000100; #1;
      chk("alu_busy",  32'(busy),  32'd1);
      chk("alu_aluop", 32'(ALUOp), 32'd1);
      chk("alu_we",    32'(we),    32'd1);
      chk("alu_wez",   32'(wez),   32'd1);
      chk("alu_pc_en", 32'(pc_en), 32'd1);
      tick();
      opcode = 6'b100001; #1;
      chk("ldi_s_inm", 32'(s_inm), 32'd1);
      chk("ldi_we",    32'(we),    32'd1);
      chk("ldi_wez",   32'(wez),   32'd0);
      chk("ldi_aluop", 32'(ALUOp), 32'd0);
      tick();
      opcode = 6'b111111; #1;
      chk("hlt_pc_en", 32'(pc_en), 32'd0);
      chk("hlt_we",    32'(we),    32'd0);
      tick();
      chk("hlt_halted", 32'(halted), 32'd1);
      chk("hlt_busy",   32'(busy),   32'd0);
      chk("hlt_count",  32'(instr_count), 32'd2);
      start = 1'b1; opcode = 6'b000000; tick();
      chk("hlt_ignore_start", 32'(halted), 32'd1);
      chk_idle("hlt_out");

      // reset from HALT with start still high
      reset = 1'b0; tick();
      chk("rsth_halted", 32'(halted), 32'd0);
      chk("rsth_busy",   32'(busy),   32'd0);
      chk("rsth_count",  32'(instr_count), 32'd0);
      tick();
      chk("rsth_hold", 32'(busy), 32'd0);
      reset = 1'b1; start = 1'b0; tick();
      chk("rsth_idle", 32'(busy), 32'd0);

      // conditional jumps and unused opcodes, all within one RUN cycle
      start = 1'b1; tick(); start = 1'b0;
      opcode = 6'b110001; zero = 1'b1; #1;
      chk("jz1_s_inc", 32'(s_inc), 32'd0);
      chk("jz1_pc_en", 32'(pc_en), 32'd1);
      chk("jz1_we",    32'(we),    32'd0);
      zero = 1'b0; #1;
      chk("jz0_s_inc", 32'(s_inc), 32'd1);
      opcode = 6'b110010; zero = 1'b1; #1;
      chk("jnz1_s_inc", 32'(s_inc), 32'd1);
      zero = 1'b0; #1;
      chk("jnz0_s_inc", 32'(s_inc), 32'd0);
      opcode = 6'b110000; #1;
      chk("j_s_inc", 32'(s_inc), 32'd0);
      chk("j_wez",   32'(wez),   32'd0);
      opcode = 6'b110011; #1;
      chk("nop1_we",    32'(we),    32'd0);
      chk("nop1_wez",   32'(wez),   32'd0);
      chk("nop1_pc_en", 32'(pc_en), 32'd1);
      opcode = 6'b101000; #1;
      chk("nop2_we",   32'(we),   32'd0);
      chk("nop2_wez",  32'(wez),  32'd0);
      chk("nop2_s_inm", 32'(s_inm), 32'd0);
      opcode = 6'b111111; tick();
      chk("jmp_halted", 32'(halted), 32'd1);
      chk("jmp_count",  32'(instr_count), 32'd0);

      // single-step mode: three start pulses four cycles apart
      reset = 1'b0; tick(); reset = 1'b1;
      step_mode = 1'b1; opcode = 6'b000000;
      runs = 0; pens = 0;
      for (int i = 0; i < 12; i++) begin
         start = (i % 4 == 0);
         tick();
         runs += int'(busy);
         pens += int'(pc_en);
      end
      start = 1'b0;
      chk("step_runs",  32'(runs), 32'd3);
      chk("step_pens",  32'(pens), 32'd3);
      chk("step_count", 32'(instr_count), 32'd3);

      // start held in WAIT alternates RUN and WAIT
      start = 1'b1;
      tick(); chk("hold_r1", 32'(busy), 32'd1);
      tick(); chk("hold_w1", 32'(busy), 32'd0);
      tick(); chk("hold_r2", 32'(busy), 32'd1);
      tick(); chk("hold_w2", 32'(busy), 32'd0);
      start = 1'b0;
      chk("hold_count", 32'(instr_count), 32'd5);
      chk_idle("wait_out");

      // saturation on a run of NOPs
      reset = 1'b0; tick(); reset = 1'b1;
      step_mode = 1'b0; opcode = 6'b110011;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      chk("sat_14", 32'(instr_count), 32'd14);
      for (int i = 0; i < 6; i++) tick();
      chk("sat_hold", 32'(instr_count), 32'hF);
      chk("sat_busy", 32'(busy), 32'd1);
      reset = 1'b0; tick();
      chk_idle("sat_rst");
      chk("sat_rst_count", 32'(instr_count), 32'd0);
      chk("sat_rst_halted", 32'(halted), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
